cobra_exec_ctrl: RTL

Execution controller for the CYBERcobra core. It sits between the board/debug command source and the core, and drives a core clock-enable and a core reset. It sequences the core through hold-in-reset, halted, free-run and counted-run (step) modes. It also counts retired instructions and optionally stops the core on a PC breakpoint.

---
 rtl/cobra_exec_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cobra_exec_ctrl.sv
// CYBERcobra execution controller: core reset, halt, run and step sequencing.
// Optional breakpoint logic is compiled in when COBRA_EXEC_BP_EN is defined.
module cobra_exec_ctrl #(
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [31:0] pc_i,
    output logic        core_en_o,
    output logic        core_rst_o,
    output logic [1:0]  state_o,
    output logic [31:0] retired_o,
    output logic        bp_hit_o
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_RST  = 2'd3;

    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_RUN_N = 3'd4;
    localparam logic [2:0] OP_RESET = 3'd7;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_rst_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_retired;
    logic        w_acc;
    logic        w_rst_cmd;
    logic        w_active;
    logic        w_match;
    logic        w_en;

    assign w_acc     = cmd_valid_i && cmd_ready_o;
    assign w_rst_cmd = w_acc && (cmd_op_i == OP_RESET);
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_CNT);

`ifdef COBRA_EXEC_BP_EN
    logic [31:0] r_bp_addr;
    logic        r_armed;
    logic        r_skip;
    logic        r_bp_hit;
    logic        w_enter_run;

    assign w_match = r_armed && (pc_i == r_bp_addr) && !r_skip && w_active;
    assign w_enter_run = (r_state == ST_HALT) &&
                         ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_CNT));
    assign bp_hit_o = r_bp_hit;

    // skip lets a resumed core execute the instruction it stopped on
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bp_addr <= '0;
            r_armed   <= 1'b0;
            r_skip    <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            if (w_acc && cmd_op_i == 3'd5) begin
                r_bp_addr <= cmd_arg_i;
                r_armed   <= 1'b1;
            end else if (w_acc && cmd_op_i == 3'd6) begin
                r_armed <= 1'b0;
            end
            if (w_enter_run)
                r_skip <= 1'b1;
            else if (w_en)
                r_skip <= 1'b0;
            r_bp_hit <= w_match && !w_rst_cmd;
        end
    end
`else
    logic w_unused_pc;

    assign w_unused_pc = ^pc_i;
    assign w_match     = 1'b0;
    assign bp_hit_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= ST_RST;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_rst_cmd) begin
            w_state_nxt = ST_RST;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_rst_cnt <= 32'd1)
                        w_state_nxt = ST_HALT;
                end
                ST_HALT: begin
                    if (w_acc && cmd_op_i == OP_RUN)
                        w_state_nxt = ST_RUN;
                    else if (w_acc && cmd_op_i == OP_STEP)
                        w_state_nxt = ST_CNT;
                    else if (w_acc && cmd_op_i == OP_RUN_N && cmd_arg_i != '0)
                        w_state_nxt = ST_CNT;
                end
                ST_RUN: begin
                    if (w_match || (w_acc && cmd_op_i == OP_HALT))
                        w_state_nxt = ST_HALT;
                end
                default: begin
                    if (w_match || r_rem == 32'd1 ||
                        (w_acc && cmd_op_i == OP_HALT))
                        w_state_nxt = ST_HALT;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready_o = (r_state != ST_RST);
        core_rst_o  = (r_state == ST_RST);
        w_en        = w_active && !w_match;
        core_en_o   = w_en;
        state_o     = r_state;
        retired_o   = r_retired;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_cnt <= 32'(RST_CYCLES);
            r_rem     <= '0;
            r_retired <= '0;
        end else begin
            if (w_rst_cmd) begin
                r_rst_cnt <= 32'(RST_CYCLES);
                r_retired <= '0;
            end else begin
                if (r_state == ST_RST)
                    r_rst_cnt <= r_rst_cnt - 32'd1;
                if (w_en)
                    r_retired <= r_retired + 32'd1;
            end
            if (r_state == ST_HALT && w_acc && cmd_op_i == OP_STEP)
                r_rem <= 32'd1;
            else if (r_state == ST_HALT && w_acc && cmd_op_i == OP_RUN_N)
                r_rem <= cmd_arg_i;
            else if (r_state == ST_CNT && w_en)
                r_rem <= r_rem - 32'd1;
        end
    end

endmodule
